// File: rtl/ahb_resp_mux.sv
// AHB data-phase response multiplexer with a default slave for unmapped addresses.
// Define AHB_DEFSLV_ERR_EN to build the two-cycle ERROR default slave and its error counter.
module ahb_resp_mux #(
   parameter int unsigned NSLV   = 3,
   parameter int unsigned SELW   = 2,
   parameter int unsigned DWIDTH = 32
) (
   input  logic                   hclk,
   input  logic                   hresetn,
   input  logic [SELW-1:0]        sel_mux,
   input  logic [1:0]             htrans,
   input  logic [NSLV*DWIDTH-1:0] slv_hrdata,
   input  logic [NSLV-1:0]        slv_hreadyout,
   input  logic [NSLV-1:0]        slv_hresp,
   output logic [DWIDTH-1:0]      hrdata,
   output logic                   hready,
   output logic                   hresp,
   output logic [7:0]             err_cnt
);

   logic [SELW-1:0]   dsel_q, dsel_d;
   logic              dmapped_q, dmapped_d;
   logic              sel_mapped;
   logic [DWIDTH-1:0] mux_rdata;
   logic              mux_ready;
   logic              mux_resp;
   logic              def_ready;
   logic              def_resp;

   assign sel_mapped = (32'(sel_mux) < NSLV);

   // Address-phase capture; hready low (slave wait or ERR1) holds the data phase.
   always_comb begin
      dsel_d    = dsel_q;
      dmapped_d = dmapped_q;
      if (hready) begin
         dsel_d    = sel_mux;
         dmapped_d = sel_mapped;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dsel_q    <= '1;
         dmapped_q <= 1'b0;
      end else begin
         dsel_q    <= dsel_d;
         dmapped_q <= dmapped_d;
      end
   end

   always_comb begin
      mux_rdata = '0;
      mux_ready = 1'b1;
      mux_resp  = 1'b0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (dsel_q == SELW'(i)) begin
            mux_rdata = slv_hrdata[i*DWIDTH +: DWIDTH];
            mux_ready = slv_hreadyout[i];
            mux_resp  = slv_hresp[i];
         end
      end
   end

   always_comb begin
      if (dmapped_q) begin
         hrdata = mux_rdata;
         hready = mux_ready;
         hresp  = mux_resp;
      end else begin
         hrdata = '0;
         hready = def_ready;
         hresp  = def_resp;
      end
   end

`ifdef AHB_DEFSLV_ERR_EN
   localparam logic [1:0] ST_OK   = 2'd0;
   localparam logic [1:0] ST_ERR1 = 2'd1;
   localparam logic [1:0] ST_ERR2 = 2'd2;

   logic [1:0] state_q, state_d;
   logic       dactive_q, dactive_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       unmapped_active;
   logic       unused_htrans;

   assign unmapped_active = !sel_mapped && htrans[1];
   assign unused_htrans   = htrans[0];

   // Next state only moves on a capture (or out of ERR1), so a mapped phase keeps ST_OK.
   always_comb begin
      state_d   = state_q;
      dactive_d = dactive_q;
      if (hready)
         dactive_d = htrans[1];
      case (state_q)
         ST_ERR1: state_d = ST_ERR2;
         ST_OK, ST_ERR2: begin
            if (hready)
               state_d = unmapped_active ? ST_ERR1 : ST_OK;
         end
         default: state_d = ST_OK;
      endcase
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_d == ST_ERR1) && (state_q != ST_ERR1) && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q   <= ST_OK;
         dactive_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         dactive_q <= dactive_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign def_ready = (state_q != ST_ERR1);
   assign def_resp  = dactive_q && ((state_q == ST_ERR1) || (state_q == ST_ERR2));
   assign err_cnt   = err_cnt_q;
`else
   logic unused_htrans;

   assign unused_htrans = &{1'b0, htrans};
   assign def_ready     = 1'b1;
   assign def_resp      = 1'b0;
   assign err_cnt       = '0;
`endif

endmodule
